// File: rtl/jregfile_pkg.sv
// Shared types and default sizing for the jregfile register file.
package jregfile_pkg;

    localparam int unsigned JREG_WIDTH_DEF = 8;
    localparam int unsigned JREG_DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : jregfile_pkg

// File: rtl/jregfile_jrdport.sv
// Combinational read port: address mux followed by an enabler that forces zero.
module jrdport
    import jregfile_pkg::*;
#(
    parameter  int unsigned WIDTH = JREG_WIDTH_DEF,
    parameter  int unsigned DEPTH = JREG_DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] data_i [DEPTH],
    output logic [WIDTH-1:0] rdata_c_o
);

    // Addresses with no matching entry fall through to zero.
    always_comb begin
        rdata_c_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (en_i && (addr_i == AW'(i))) begin
                rdata_c_o = data_i[i];
            end
        end
    end

endmodule : jrdport

// File: rtl/jregfile.sv
// Flip-flop register file with one write port, two enabled read ports and a
// sequential clear engine that walks every entry one per cycle.
module jregfile
    import jregfile_pkg::*;
#(
    parameter  int unsigned WIDTH = JREG_WIDTH_DEF,
    parameter  int unsigned DEPTH = JREG_DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ws,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wea,
    input  logic [AW-1:0]    raddra,
    output logic [WIDTH-1:0] boa,
    input  logic             web,
    input  logic [AW-1:0]    raddrb,
    output logic [WIDTH-1:0] bob,
    input  logic             clr,
    output logic             busy,
    output logic [DEPTH-1:0] valid
);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q;
    logic             write_en_c;
    logic             clear_en_c;
    logic             waddr_ok_c;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    assign waddr_ok_c = (32'(waddr) < DEPTH);

    // State, clear counter and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    // Next state: a clear walks cnt from 0 up to DEPTH-1, one entry per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath controls: writes only land while idle, the clear owns CLEAR.
    always_comb begin
        write_en_c = 1'b0;
        clear_en_c = 1'b0;
        case (state_q)
            IDLE:    write_en_c = ws && waddr_ok_c;
            CLEAR:   clear_en_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (write_en_c && (waddr == AW'(i))) begin
                    mem_q[i]   <= wdata;
                    valid_q[i] <= 1'b1;
                end else if (clear_en_c && (cnt_q == AW'(i))) begin
                    mem_q[i]   <= '0;
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;

    // Reset also gates the read enables so both ports read zero while held.
    jrdport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rdport_a (
        .en_i      (wea & reset_n),
        .addr_i    (raddra),
        .data_i    (mem_q),
        .rdata_c_o (boa)
    );

    jrdport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rdport_b (
        .en_i      (web & reset_n),
        .addr_i    (raddrb),
        .data_i    (mem_q),
        .rdata_c_o (bob)
    );

endmodule : jregfile
